cla_result_fifo: RTL and testbench

Downstream capture stage for the 32-bit carry-lookahead adder (`rdcla`). It accepts each registered sum and carry-out from the adder, tags it with a signed-overflow flag, and buffers it in a small show-ahead FIFO. A valid/ready handshake on the output side lets a slower consumer, such as a writeback or result checker, drain results at its own pace. Results offered while the buffer is full are counted and discarded.

---
 rtl/cla_result_fifo.sv | 124 ++++++++++++
 tb/tb_cla_result_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cla_result_fifo.sv
// rtl/cla_result_fifo.sv - show-ahead result FIFO behind the rdcla adder, with drop counter (option: CLA_RESULT_OVF_EN)
module cla_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_sum,
    input  logic                     in_cout,
    input  logic                     in_a_msb,
    input  logic                     in_b_msb,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_cout,
    output logic                     out_ovf,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
`ifdef CLA_RESULT_OVF_EN
    localparam int EW = WIDTH + 2;
`else
    localparam int EW = WIDTH + 1;
`endif

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_drop_cnt;

    logic          w_empty;
    logic          w_full;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;

    // Full/empty come from the registered pointers only; the extra MSB tells a lap apart
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_en = in_valid && !w_full;
    assign w_rd_en = !w_empty && out_ready;

`ifdef CLA_RESULT_OVF_EN
    logic w_ovf;
    // Two's-complement overflow of a+b: like-signed operands giving a differently signed sum
    assign w_ovf   = (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb);
    assign w_entry = {w_ovf, in_cout, in_sum};
`else
    logic w_unused_msbs;
    assign w_unused_msbs = in_a_msb ^ in_b_msb;
    assign w_entry       = {in_cout, in_sum};
`endif

    // Entry storage, cleared on reset so a fresh FIFO never exposes stale results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
        end
    end

    // Pointer advance on accepted writes and reads; natural wrap of the AW+1 bit pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Occupancy moves by at most one per cycle; a simultaneous read and write leaves it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Count offers rejected because the FIFO was full, sticking at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (in_valid && w_full && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // Show-ahead head entry, zeroed whenever nothing is valid
    always_comb begin
        w_head   = r_mem[r_rd_ptr[AW-1:0]];
        out_sum  = '0;
        out_cout = 1'b0;
        out_ovf  = 1'b0;
        if (!w_empty) begin
            out_sum  = w_head[WIDTH-1:0];
            out_cout = w_head[WIDTH];
`ifdef CLA_RESULT_OVF_EN
            out_ovf  = w_head[WIDTH+1];
`endif
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign count     = r_count;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_cla_result_fifo.sv
// tb/tb_cla_result_fifo.sv - directed self-checking bench for cla_result_fifo
module tb_cla_result_fifo;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_sum;
    logic        in_cout;
    logic        in_a_msb;
    logic        in_b_msb;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;

    int n_cmp;
    int n_bad;

    cla_result_fifo #(.WIDTH(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .in_a_msb  (in_a_msb),
        .in_b_msb  (in_b_msb),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .count     (count),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic exp_ovf1;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_sum = '0; in_cout = 1'b0;
        in_a_msb = 1'b0; in_b_msb = 1'b0; out_ready = 1'b0;
`ifdef CLA_RESULT_OVF_EN
        exp_ovf1 = 1'b1;
`else
        exp_ovf1 = 1'b0;
`endif
        do_reset();

        // reset then idle
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready",  in_ready,  1);
        check_val("rst_count",     count,     0);
        check_val("rst_drop",      drop_cnt,  0);
        check_val("rst_out_sum",   out_sum,   0);

        // single pass
        in_valid = 1'b1; in_sum = 32'h5; in_cout = 1'b0;
        step();
        in_valid = 1'b0;
        check_val("single_valid", out_valid, 1);
        check_val("single_sum",   out_sum,   32'h5);
        check_val("single_count", count,     1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("single_empty_valid", out_valid, 0);
        check_val("single_empty_count", count,     0);
        check_val("single_empty_sum",   out_sum,   0);

        // fill and drop: six offers into four slots
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_sum = 32'(i);
            step();
        end
        in_valid = 1'b0;
        check_val("fill_count",    count,    4);
        check_val("fill_in_ready", in_ready, 0);
        check_val("fill_drop",     drop_cnt, 2);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_val($sformatf("drain_sum%0d", i), out_sum, 64'(i));
            step();
            if (i == 1) check_val("drain_in_ready_rise", in_ready, 1);
        end
        out_ready = 1'b0;
        check_val("drain_count", count, 0);

        // wrap with simultaneous read and write
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_sum = 32'(100 + i);
            step();
            check_val($sformatf("wrap_count%0d", i), count,   1);
            check_val($sformatf("wrap_sum%0d", i),   out_sum, 64'(100 + i));
        end
        in_valid = 1'b0;
        step();
        check_val("wrap_final_count", count,    0);
        check_val("wrap_drop",        drop_cnt, 0);

        // overflow flag
        out_ready = 1'b0;
        in_valid = 1'b1; in_sum = 32'h8000_0000; in_cout = 1'b0;
        in_a_msb = 1'b0; in_b_msb = 1'b0;
        step();
        check_val("ovf1_sum",  out_sum,  32'h8000_0000);
        check_val("ovf1_ovf",  out_ovf,  exp_ovf1);
        check_val("ovf1_cout", out_cout, 0);
        out_ready = 1'b1;
        in_sum = 32'h0; in_cout = 1'b1; in_a_msb = 1'b1; in_b_msb = 1'b0;
        step();
        in_valid = 1'b0;
        check_val("ovf2_valid", out_valid, 1);
        check_val("ovf2_sum",   out_sum,   0);
        check_val("ovf2_cout",  out_cout,  1);
        check_val("ovf2_ovf",   out_ovf,   0);
        step();
        out_ready = 1'b0;
        in_cout = 1'b0; in_a_msb = 1'b0; in_b_msb = 1'b0;
        check_val("ovf_empty_count", count, 0);

        // reset mid-operation: 3 queued, drop count 5
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1; in_sum = 32'(i + 40);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("mid_count", count,    3);
        check_val("mid_drop",  drop_cnt, 5);
        check_val("mid_head",  out_sum,  42);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_out_valid", out_valid, 0);
        check_val("async_in_ready",  in_ready,  1);
        check_val("async_count",     count,     0);
        check_val("async_drop",      drop_cnt,  0);
        check_val("async_out_sum",   out_sum,   0);
        step();
        rst_n = 1'b1;
        step();
        check_val("post_rst_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
